// File: rtl/div_iter_unit_if.sv
// Request/response bundle between dispatch and the iterative divider.
// The master issues divide requests; the slave returns one result per accepted request.
interface div_iter_unit_if;
    logic        kill_i;
    logic        valid_i;
    logic        ready_o;
    logic        op_signed_i;
    logic        op_word_i;
    logic        op_rem_i;
    logic [63:0] dividend_i;
    logic [63:0] divisor_i;
    logic        valid_o;
    logic [63:0] result_o;

    modport master (
        output kill_i, valid_i, op_signed_i, op_word_i, op_rem_i,
        output dividend_i, divisor_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  kill_i, valid_i, op_signed_i, op_word_i, op_rem_i,
        input  dividend_i, divisor_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/div_iter_unit.sv
// Iterative 64-bit divider for the execute stage, 2*SLICES_PER_CYCLE quotient bits per cycle.
// Define DIV_SPECIAL_FAST_EN to skip the iterations for divide-by-zero and signed overflow.
module div_iter_unit #(
    parameter int SLICES_PER_CYCLE = 1
) (
    input logic           clk_i,
    input logic           rst_i,
    div_iter_unit_if.slave io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         NFULL = 32 / SLICES_PER_CYCLE;
    localparam logic [5:0] N64   = 6'(NFULL);
    localparam logic [5:0] NWORD = 6'(NFULL / 2);
    localparam logic [63:0] MIN64 = {1'b1, 63'd0};
    localparam logic [63:0] MINW  = {{33{1'b1}}, 31'd0};

    // Restoring slice: two quotient bits per call; the borrow of the trial
    // subtraction decides each bit.
    function automatic logic [127:0] div_4bits(
        input logic [63:0] rem,
        input logic [63:0] dq,
        input logic [63:0] dvs
    );
        logic [64:0] t;
        logic [64:0] diff;
        logic [63:0] r;
        logic [63:0] d;
        r = rem;
        d = dq;
        for (int b = 0; b < 2; b++) begin
            t    = {r, d[63]};
            diff = t - {1'b0, dvs};
            d    = {d[62:0], ~diff[64]};
            r    = diff[64] ? t[63:0] : diff[63:0];
        end
        return {r, d};
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] dq_q, dq_d;
    logic [63:0] dvs_q, dvs_d;
    logic [63:0] orig_q, orig_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        word_q, word_d;
    logic        remop_q, remop_d;
    logic        div0_q, div0_d;
    logic        ovf_q, ovf_d;

    logic        acc;
    logic [63:0] dvd_e, dvs_e;
    logic        sd, sv;
    logic [63:0] abs_dvd, abs_dvs;
    logic        is_div0, is_ovf;
    logic [127:0] step;
    logic [63:0] q, r, res;

    always_comb begin
        acc     = io.valid_i & (state_q == IDLE) & ~io.kill_i;
        dvd_e   = io.dividend_i;
        dvs_e   = io.divisor_i;
        if (io.op_word_i) begin
            dvd_e = {{32{io.op_signed_i & io.dividend_i[31]}}, io.dividend_i[31:0]};
            dvs_e = {{32{io.op_signed_i & io.divisor_i[31]}}, io.divisor_i[31:0]};
        end
        sd      = io.op_signed_i & dvd_e[63];
        sv      = io.op_signed_i & dvs_e[63];
        abs_dvd = sd ? -dvd_e : dvd_e;
        abs_dvs = sv ? -dvs_e : dvs_e;
        is_div0 = (dvs_e == 64'd0);
        is_ovf  = io.op_signed_i & (dvs_e == '1)
                & (dvd_e == (io.op_word_i ? MINW : MIN64));

        step = {rem_q, dq_q};
        for (int s = 0; s < SLICES_PER_CYCLE; s++) begin
            step = div_4bits(step[127:64], step[63:0], dvs_q);
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        orig_d  = orig_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        word_d  = word_q;
        remop_d = remop_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    rem_d   = 64'd0;
                    dq_d    = io.op_word_i ? {abs_dvd[31:0], 32'd0} : abs_dvd;
                    dvs_d   = abs_dvs;
                    orig_d  = dvd_e;
                    negq_d  = sd ^ sv;
                    negr_d  = sd;
                    word_d  = io.op_word_i;
                    remop_d = io.op_rem_i;
                    div0_d  = is_div0;
                    ovf_d   = is_ovf;
                    cnt_d   = io.op_word_i ? NWORD : N64;
                    state_d = ITER;
`ifdef DIV_SPECIAL_FAST_EN
                    if (is_div0 | is_ovf) state_d = DONE;
`else
                    state_d = ITER;
`endif
                end
            end
            ITER: begin
                rem_d = step[127:64];
                dq_d  = step[63:0];
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (io.kill_i) state_d = IDLE;

        q = negq_q ? -dq_q : dq_q;
        r = negr_q ? -rem_q : rem_q;
        // Overflow quotient equals the dividend itself (the MIN value).
        if (div0_q) begin
            q = '1;
            r = orig_q;
        end else if (ovf_q) begin
            q = orig_q;
            r = 64'd0;
        end
        res = remop_q ? r : q;
        if (word_q) res = {{32{res[31]}}, res[31:0]};
    end

    assign io.ready_o  = (state_q == IDLE);
    assign io.valid_o  = (state_q == DONE) & ~io.kill_i;
    assign io.result_o = io.valid_o ? res : 64'd0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            orig_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            word_q  <= 1'b0;
            remop_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            orig_q  <= orig_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            word_q  <= word_d;
            remop_q <= remop_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
